dmem_unit: RTL and testbench
============================

# dmem_unit

Parametrised byte-addressed data memory for the MEM stage of the RV32 pipeline, successor to the fixed 1000-byte array. It accepts load/store requests through a valid/ready handshake and performs synchronous reads with one-cycle latency. Load data is sign- or zero-extended per funct3, and out-of-range, illegal or misaligned accesses are reported as faults rather than silently aliased. Storage is four byte-lane banks, so any store is a single write cycle per word.

## Interface
- DEPTH_BYTES, 1024: capacity in bytes; a multiple of 4 and a power of two.
- BASE_ADDR, 32'h0000_0000: byte address that maps to bank word 0, lane 0.
- ADDR_W, 32: width of the request address.
- clk  in  1  clock; everything samples on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 size/sign code.
- req_addr  in  ADDR_W  byte address (ALU result).
- req_wdata  in  32  store data, LSB-aligned.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  1  access was rejected; no memory change.

## Operation
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. Requests are single-cycle. The response has no backpressure.
- Offset: off = req_addr - BASE_ADDR (ADDR_W bits, unsigned); word = off >> 2; lane = off[1:0].
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code gives a fault.
- Fault if any accessed byte has off >= DEPTH_BYTES. The range is checked over the full access span before any write, so no partial write ever occurs on a fault.
- Store: per-lane byte enables from size and lane. Data is rotated so that wdata[7:0] lands at the lowest addressed byte (little-endian).
- Load: the word is read synchronously. The response stage uses the registered funct3/lane to select bytes and extend (sign for LB/LH, zero for LBU/LHU).
- FSM (state in package):
  - IDLE: req_ready=1. An access contained in one word completes in one cycle. A word-crossing access (only when split is enabled) goes to SPLIT.
  - SPLIT: req_ready=0. The high word (word+1) is read or written and the low-word load data is held. Returns to IDLE.
- Fault requests: no bank access; response next cycle with rsp_fault=1 and rsp_rdata=0.
- Memory contents are not reset; they are undefined until written.

## Timing
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_fault=0, state=IDLE. req_ready=1 after reset deassertion.
- Single-word access or fault accepted at edge T: rsp_valid is high during cycle T+1. Throughput is one request per cycle.
- Split access accepted at T:
  - Low word is written/read at T, high word at T+1.
  - Response is at T+2.
  - req_ready is low during cycle T+1.
- Load immediately after a store to the same byte (back-to-back cycles) returns the new data, because the write completes at edge T before the read at edge T+1.
- Reset mid-SPLIT: return to IDLE with no response. For a store, the low word is already written and the high word is not.
- Address wrap: an access whose span wraps past 2^ADDR_W - 1 is a fault.

## Configuration
- DMEM_MISALIGN_SPLIT_EN defined:
  - A misaligned access within one word (e.g. LH at lane 1) completes in one cycle.
  - A word-crossing access takes the two-cycle SPLIT path.
- DMEM_MISALIGN_SPLIT_EN undefined:
  - Any half access with lane[0]=1, or any word access with lane!=0, is a fault.
  - The SPLIT state and its holding registers are not built, and req_ready is tied to 1.

## Structure
- dmem_pkg contains:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - The state enum {IDLE, SPLIT}.
  - A 4-bit lane-enable type.
  - The byte-enable/rotate function shared by the store and load paths.
- Sub-module dmem_bank is one 8-bit-wide synchronous RAM of DEPTH_BYTES/4 entries with a write enable and registered read. It is instantiated four times, one per lane.

## Test plan
- SW 0x1234_5678 @BASE+8, then LW @BASE+8 next cycle: rsp_rdata=0x1234_5678 one cycle after acceptance.
- Sign and zero extension, with byte 0x80 at BASE+8:
  - LB @BASE+8: 0xFFFF_FF80.
  - LBU @BASE+8: 0x0000_0080.
  - LHU @BASE+8: 0x0000_5680 (low bytes 0x80, 0x56).
- LW @BASE+DEPTH_BYTES-2: rsp_fault=1, rsp_rdata=0; a following LW at that word shows no bytes changed.
- Misaligned word access, with bytes BASE+0..7 = 0x00..0x07:
  - With the macro: SW 0xAABB_CCDD @BASE+3 then LW @BASE+3 returns 0xAABB_CCDD; the store's req_ready is low for one cycle and its response arrives at T+2.
  - Without the macro: the SW @BASE+3 faults and the bytes are unchanged.
- Illegal funct3=011 load and funct3=100 store: each faults, with no write.
- Assert rst_n low during SPLIT of the SW @BASE+3: no rsp_valid. Low-word bytes BASE+3 read 0xDD; BASE+4..6 keep their old values.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: RV32 funct3 size codes,
// the split-access state type, the lane-enable type and the byte span/rotate
// helpers used by both the store path and the load path.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } dmem_state_e;

  typedef logic [3:0] lane_en_t;

  // Number of bytes touched by a load code; zero marks an unknown code.
  function automatic logic [2:0] access_bytes(input logic [2:0] f3);
    logic [2:0] n;
    case (f3)
      F3_B, F3_BU: n = 3'd1;
      F3_H, F3_HU: n = 3'd2;
      F3_W:        n = 3'd4;
      default:     n = 3'd0;
    endcase
    return n;
  endfunction

  // Byte enables over two consecutive words: the low nibble selects lanes of
  // the addressed word, the high nibble lanes of the following word.
  function automatic logic [7:0] span_mask(input logic [2:0] f3, input logic [1:0] lane);
    logic [7:0] base;
    case (f3)
      F3_B, F3_BU: base = 8'b0000_0001;
      F3_H, F3_HU: base = 8'b0000_0011;
      F3_W:        base = 8'b0000_1111;
      default:     base = 8'b0000_0000;
    endcase
    return base << lane;
  endfunction

  // Circular byte rotation by the lane offset. Rotating left places byte 0 of
  // store data on the addressed lane; rotating right brings the addressed lane
  // back to byte 0 of load data. Because each bank holds exactly one byte of
  // the access, the same rotation serves both single-word and split accesses.
  function automatic logic [31:0] lane_rotate(input logic [31:0] data,
                                              input logic [1:0]  lane,
                                              input logic        to_lanes);
    logic [63:0] dbl;
    logic [4:0]  amt;
    dbl = {data, data};
    amt = {lane, 3'b000};
    if (to_lanes) begin
      dbl = dbl << amt;
      return dbl[63:32];
    end
    dbl = dbl >> amt;
    return dbl[31:0];
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte lane of the data memory: an 8-bit synchronous RAM with a write
// enable and a registered read that holds its value while re is low.
module dmem_bank #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [WORDS];

  // Write port and registered read port share the single address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_unit.sv
// Byte-addressed data memory for the RV32 MEM stage. Requests use a
// valid/ready handshake, loads return one cycle after acceptance, and illegal,
// out-of-range, wrapping or (by default) misaligned accesses return a fault.
// Defining DMEM_MISALIGN_SPLIT_EN allows misaligned accesses; those that cross
// a word boundary take an extra SPLIT cycle for the high word.
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int          DEPTH_BYTES = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault
);

  localparam int                WORDS     = DEPTH_BYTES / 4;
  localparam int                WORD_W    = $clog2(WORDS);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH_BYTES);

  logic [ADDR_W-1:0] off;
  logic [ADDR_W:0]   last_off;
  logic [ADDR_W:0]   last_addr;
  logic [2:0]        nbytes;
  logic [1:0]        lane;
  logic [WORD_W-1:0] word;
  logic [7:0]        span;
  logic              crossing;
  logic              f3_ok;
  logic              misaligned;
  logic              req_fault;
  logic              split_start;
  logic              accept;
  logic [31:0]       wdata_rot;

  lane_en_t          bank_we;
  lane_en_t          bank_re;
  logic [WORD_W-1:0] bank_addr;
  logic [31:0]       bank_wdata;
  logic [7:0]        bank_rdata [4];

  logic              rsp_valid_q;
  logic              rsp_fault_q;
  logic              rsp_load_q;
  logic [2:0]        rsp_f3_q;
  logic [1:0]        rsp_lane_q;
  logic [31:0]       raw_word;
  logic [31:0]       aligned;
  logic [31:0]       ext_data;

`ifdef DMEM_MISALIGN_SPLIT_EN
  dmem_state_e       state_q;
  dmem_state_e       state_d;
  logic [WORD_W-1:0] split_word_q;
  lane_en_t          split_lanes_q;
  logic              split_we_q;
  logic [31:0]       split_wdata_q;
  logic [2:0]        split_f3_q;
  logic [1:0]        split_lane_q;
`endif

  // Decode the request: offset, size, span over the word pair, and fault reasons.
  always_comb begin
    off        = req_addr - BASE;
    lane       = off[1:0];
    word       = off[WORD_W+1:2];
    nbytes     = access_bytes(req_funct3);
    span       = span_mask(req_funct3, lane);
    crossing   = |span[7:4];
    f3_ok      = req_we ? (req_funct3 inside {F3_B, F3_H, F3_W}) : (nbytes != 3'd0);
    last_off   = {1'b0, off} + (ADDR_W+1)'(nbytes - 3'd1);
    last_addr  = {1'b0, req_addr} + (ADDR_W+1)'(nbytes - 3'd1);
`ifdef DMEM_MISALIGN_SPLIT_EN
    misaligned = 1'b0;
`else
    misaligned = ((nbytes == 3'd2) && lane[0]) || ((nbytes == 3'd4) && (lane != 2'd0)) || crossing;
`endif
    req_fault  = !f3_ok || (last_off >= DEPTH_EXT) || last_addr[ADDR_W] || misaligned;
`ifdef DMEM_MISALIGN_SPLIT_EN
    split_start = crossing && !req_fault;
`else
    split_start = 1'b0;
`endif
    accept     = req_valid && req_ready;
    wdata_rot  = lane_rotate(req_wdata, lane, 1'b1);
  end

`ifdef DMEM_MISALIGN_SPLIT_EN
  // Split-access state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and ready: a word-crossing access spends one extra cycle in SPLIT.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b1;
    case (state_q)
      IDLE: begin
        if (req_valid && split_start) begin
          state_d = SPLIT;
        end
      end
      SPLIT: begin
        req_ready = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture what the high-word cycle needs when a split access is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      split_word_q  <= '0;
      split_lanes_q <= '0;
      split_we_q    <= 1'b0;
      split_wdata_q <= '0;
      split_f3_q    <= F3_B;
      split_lane_q  <= 2'd0;
    end else if (accept && split_start) begin
      split_word_q  <= word + WORD_W'(1);
      split_lanes_q <= span[7:4];
      split_we_q    <= req_we;
      split_wdata_q <= wdata_rot;
      split_f3_q    <= req_funct3;
      split_lane_q  <= lane;
    end
  end
`else
  assign req_ready = 1'b1;
`endif

  // Drive the banks: low-word lanes on acceptance, high-word lanes during SPLIT.
  always_comb begin
    bank_addr  = word;
    bank_wdata = wdata_rot;
    bank_we    = '0;
    bank_re    = '0;
    if (accept && !req_fault) begin
      if (req_we) begin
        bank_we = span[3:0];
      end else begin
        bank_re = span[3:0];
      end
    end
`ifdef DMEM_MISALIGN_SPLIT_EN
    if (state_q == SPLIT) begin
      bank_addr  = split_word_q;
      bank_wdata = split_wdata_q;
      if (split_we_q) begin
        bank_we = split_lanes_q;
      end else begin
        bank_re = split_lanes_q;
      end
    end
`endif
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    dmem_bank #(
      .WORDS (WORDS),
      .AW    (WORD_W)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[g]),
      .re    (bank_re[g]),
      .addr  (bank_addr),
      .wdata (bank_wdata[8*g +: 8]),
      .rdata (bank_rdata[g])
    );
  end

  // Response stage: remember what completes next cycle and how to extend it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_load_q  <= 1'b0;
      rsp_f3_q    <= F3_B;
      rsp_lane_q  <= 2'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_load_q  <= 1'b0;
      if (accept) begin
        if (req_fault) begin
          rsp_valid_q <= 1'b1;
          rsp_fault_q <= 1'b1;
        end else if (!split_start) begin
          rsp_valid_q <= 1'b1;
          rsp_load_q  <= !req_we;
          rsp_f3_q    <= req_funct3;
          rsp_lane_q  <= lane;
        end
      end
`ifdef DMEM_MISALIGN_SPLIT_EN
      if (state_q == SPLIT) begin
        rsp_valid_q <= 1'b1;
        rsp_load_q  <= !split_we_q;
        rsp_f3_q    <= split_f3_q;
        rsp_lane_q  <= split_lane_q;
      end
`endif
    end
  end

  // Reassemble the loaded bytes and sign- or zero-extend by size code.
  always_comb begin
    raw_word = {bank_rdata[3], bank_rdata[2], bank_rdata[1], bank_rdata[0]};
    aligned  = lane_rotate(raw_word, rsp_lane_q, 1'b0);
    case (rsp_f3_q)
      F3_B:    ext_data = {{24{aligned[7]}}, aligned[7:0]};
      F3_BU:   ext_data = {24'd0, aligned[7:0]};
      F3_H:    ext_data = {{16{aligned[15]}}, aligned[15:0]};
      F3_HU:   ext_data = {16'd0, aligned[15:0]};
      default: ext_data = aligned;
    endcase
    rsp_rdata = (rsp_valid_q && rsp_load_q) ? ext_data : 32'd0;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: directed scenarios followed by random
// accesses, all compared against a byte-array model of the memory.
module tb_dmem_unit;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_model [DEPTH];

  dmem_unit #(
    .DEPTH_BYTES (DEPTH),
    .BASE_ADDR   (BASE),
    .ADDR_W      (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: size/sign from funct3, offset modulo 2^32, bytes little-endian.
  function automatic void modelAccess(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] wdata, output bit fault,
                                      output logic [31:0] rdata, output int lat);
    int          n;
    bit          sgn;
    logic [31:0] off32;
    longint      off;
    longint      lane;
    logic [31:0] v;
    n = 0;
    sgn = 0;
    case (f3)
      3'd0: begin n = 1; sgn = 1; end
      3'd1: begin n = 2; sgn = 1; end
      3'd2: n = 4;
      3'd4: n = 1;
      3'd5: n = 2;
      default: n = 0;
    endcase
    if (we && f3 > 3'd2) n = 0;
    off32 = addr - BASE;
    off   = longint'({32'b0, off32});
    lane  = off % 4;
    fault = (n == 0) || (off + n > DEPTH) || (longint'({32'b0, addr}) + n > 64'h1_0000_0000);
`ifdef DMEM_MISALIGN_SPLIT_EN
    lat = (lane + n > 4) ? 2 : 1;
`else
    if ((n == 2 && lane % 2 == 1) || (n == 4 && lane != 0)) fault = 1;
    lat = 1;
`endif
    rdata = 32'd0;
    if (fault) begin
      lat = 1;
      return;
    end
    if (we) begin
      for (int k = 0; k < n; k++) mem_model[off + k] = wdata[8*k +: 8];
    end else begin
      v = 32'd0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = mem_model[off + k];
      if (sgn && v[8*n-1]) begin
        for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
      end
      rdata = v;
    end
  endfunction

  // Present one request, then wait (bounded) for its response.
  task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, output bit fault,
                               output logic [31:0] rdata, output int lat, output logic ready_mid);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    ready_mid = req_ready;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 4) begin
      @(posedge clk);
      #1;
      lat++;
    end
    fault = rsp_fault;
    rdata = rsp_rdata;
  endtask

  task automatic runAccess(input string tag, input bit we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] got);
    bit          exp_fault;
    logic [31:0] exp_rdata;
    int          exp_lat;
    bit          got_fault;
    int          lat;
    logic        ready_mid;
    modelAccess(we, f3, addr, wdata, exp_fault, exp_rdata, exp_lat);
    applyStimulus(we, f3, addr, wdata, got_fault, got, lat, ready_mid);
    checkOutput({tag, ".fault"}, 32'(got_fault), 32'(exp_fault));
    checkOutput({tag, ".rdata"}, got, exp_rdata);
    checkOutput({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    if (exp_lat == 2) checkOutput({tag, ".ready_mid"}, 32'(ready_mid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] addr;
    logic [2:0]  f3;
    bit          we;
    bit          saw_rsp;
    int          sel;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset.rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset.rsp_fault", 32'(rsp_fault), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset.req_ready", 32'(req_ready), 32'd1);

    // Fill every word so later loads have defined contents.
    for (int w = 0; w < DEPTH / 4; w++) begin
      runAccess("init", 1'b1, 3'd2, BASE + 32'(4 * w), $urandom, got);
    end

    runAccess("sw8", 1'b1, 3'd2, BASE + 32'd8, 32'h1234_5678, got);
    runAccess("lw8", 1'b0, 3'd2, BASE + 32'd8, 32'd0, got);
    checkOutput("lw8.value", got, 32'h1234_5678);

    runAccess("sb8", 1'b1, 3'd0, BASE + 32'd8, 32'h0000_0080, got);
    runAccess("lb8", 1'b0, 3'd0, BASE + 32'd8, 32'd0, got);
    checkOutput("lb8.value", got, 32'hFFFF_FF80);
    runAccess("lbu8", 1'b0, 3'd4, BASE + 32'd8, 32'd0, got);
    checkOutput("lbu8.value", got, 32'h0000_0080);
    runAccess("lhu8", 1'b0, 3'd5, BASE + 32'd8, 32'd0, got);
    checkOutput("lhu8.value", got, 32'h0000_5680);

    runAccess("lw_end", 1'b0, 3'd2, BASE + 32'(DEPTH - 2), 32'd0, got);
    checkOutput("lw_end.value", got, 32'd0);
    runAccess("sw_end", 1'b1, 3'd2, BASE + 32'(DEPTH - 2), 32'hDEAD_BEEF, got);
    runAccess("lw_last", 1'b0, 3'd2, BASE + 32'(DEPTH - 4), 32'd0, got);
    runAccess("lw_below", 1'b0, 3'd2, BASE - 32'd4, 32'd0, got);
    runAccess("lw_wrap", 1'b0, 3'd2, 32'hFFFF_FFFE, 32'd0, got);

    runAccess("init0", 1'b1, 3'd2, BASE, 32'h0302_0100, got);
    runAccess("init4", 1'b1, 3'd2, BASE + 32'd4, 32'h0706_0504, got);
    runAccess("sw3", 1'b1, 3'd2, BASE + 32'd3, 32'hAABB_CCDD, got);
`ifdef DMEM_MISALIGN_SPLIT_EN
    runAccess("lw3", 1'b0, 3'd2, BASE + 32'd3, 32'd0, got);
    checkOutput("lw3.value", got, 32'hAABB_CCDD);
    runAccess("lh7", 1'b0, 3'd1, BASE + 32'd7, 32'd0, got);
    runAccess("lhu1", 1'b0, 3'd5, BASE + 32'd1, 32'd0, got);
`else
    runAccess("lw0", 1'b0, 3'd2, BASE, 32'd0, got);
    checkOutput("lw0.value", got, 32'h0302_0100);
    runAccess("lw4", 1'b0, 3'd2, BASE + 32'd4, 32'd0, got);
    checkOutput("lw4.value", got, 32'h0706_0504);
    runAccess("lh1", 1'b0, 3'd1, BASE + 32'd1, 32'd0, got);
`endif

    runAccess("ld_f3_011", 1'b0, 3'd3, BASE + 32'd8, 32'd0, got);
    runAccess("st_f3_100", 1'b1, 3'd4, BASE + 32'd8, 32'hFFFF_FFFF, got);
    runAccess("st_f3_101", 1'b1, 3'd5, BASE + 32'd12, 32'hFFFF_FFFF, got);
    runAccess("lw8_after", 1'b0, 3'd2, BASE + 32'd8, 32'd0, got);
    checkOutput("lw8_after.value", got, 32'h1234_5680);

`ifdef DMEM_MISALIGN_SPLIT_EN
    runAccess("reinit0", 1'b1, 3'd2, BASE, 32'h0302_0100, got);
    runAccess("reinit4", 1'b1, 3'd2, BASE + 32'd4, 32'h0706_0504, got);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = BASE + 32'd3;
    req_wdata  = 32'hAABB_CCDD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("rst_split.ready_mid", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    mem_model[3] = 8'hDD;
    #1;
    saw_rsp = rsp_valid;
    repeat (2) begin
      @(posedge clk);
      #1;
      saw_rsp = saw_rsp | rsp_valid;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      saw_rsp = saw_rsp | rsp_valid;
    end
    checkOutput("rst_split.no_rsp", 32'(saw_rsp), 32'd0);
    checkOutput("rst_split.ready", 32'(req_ready), 32'd1);
    runAccess("rst_split.lbu3", 1'b0, 3'd4, BASE + 32'd3, 32'd0, got);
    checkOutput("rst_split.lbu3.value", got, 32'h0000_00DD);
    runAccess("rst_split.lw4", 1'b0, 3'd2, BASE + 32'd4, 32'd0, got);
    checkOutput("rst_split.lw4.value", got, 32'h0706_0504);
`endif

    for (int i = 0; i < 400; i++) begin
      we  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        addr = $urandom;
      end else if (sel == 1) begin
        addr = BASE + 32'(DEPTH - 4) + 32'($urandom_range(0, 7));
      end else begin
        addr = BASE + 32'($urandom_range(0, DEPTH - 1));
      end
      runAccess("rand", we, f3, addr, $urandom, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
